// File: rtl/imem_dump.sv
// Instruction-memory readback streamer. It reads imem[start..end] with modular address
// wrap and emits each word as a {adr_hi, adr_lo, data MSB-first} frame that the loader accepts.
module imem_dump #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 40
) (
    input  logic              clk_int,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_abort,
    input  logic [ADR_W-1:0]  start_adr,
    input  logic [ADR_W-1:0]  end_adr,
    output logic              mem_rd_en,
    output logic [ADR_W-1:0]  mem_rd_adr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ack,
    output logic              byte_last,
    output logic              busy,
    output logic              done
);
    localparam int NBYTES = 2 + DATA_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  cur_adr_q, cur_adr_d;
    logic [ADR_W-1:0]  last_adr_q, last_adr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_d;
    logic [15:0]       adr_ext;
    logic [7:0]        frame_bytes [NBYTES];
    logic [7:0]        byte_sel;

    // Frame bytes are built from next-state values so every output can be registered.
    assign adr_ext        = 16'(cur_adr_d);
    assign frame_bytes[0] = adr_ext[15:8];
    assign frame_bytes[1] = adr_ext[7:0];

    genvar gi;
    generate
        for (gi = 2; gi < NBYTES; gi++) begin : g_word_bytes
            assign frame_bytes[gi] = word_d[DATA_W - 1 - 8 * (gi - 2) -: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_d == IDX_W'(i)) begin
                byte_sel = frame_bytes[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_adr_d  = cur_adr_q;
        last_adr_d = last_adr_q;
        word_d     = word_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        if (dump_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        cur_adr_d  = start_adr;
                        last_adr_d = end_adr;
                        state_d    = READ;
                    end
                end
                READ: state_d = CAPT;
                CAPT: begin
                    word_d  = mem_rd_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
                SEND: begin
                    // byte_valid is high exactly while in SEND, so byte_ack alone marks a transfer.
                    if (byte_ack) begin
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + 1'b1;
                        end else if (cur_adr_q == last_adr_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cur_adr_d = cur_adr_q + 1'b1;
                            state_d   = READ;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_int) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_adr_q  <= '0;
            last_adr_q <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            mem_rd_en  <= 1'b0;
            mem_rd_adr <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_adr_q  <= cur_adr_d;
            last_adr_q <= last_adr_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            mem_rd_en  <= (state_d == READ);
            if (state_d == READ) begin
                mem_rd_adr <= cur_adr_d;
            end
            byte_valid <= (state_d == SEND);
            byte_out   <= (state_d == SEND) ? byte_sel : 8'h00;
            byte_last  <= (state_d == SEND) && (idx_d == LAST_IDX) && (cur_adr_d == last_adr_d);
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end
endmodule
